// File: rtl/mul24_share_pkg.sv
// Shared widths for the 4-way time-shared 24x24 multiplier block.
package mul24_share_pkg;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned OPW   = 24;
    localparam int unsigned PRODW = 48;

    typedef logic [IDW-1:0]   req_id_t;
    typedef logic [OPW-1:0]   operand_t;
    typedef logic [PRODW-1:0] product_t;
endpackage

// File: rtl/mul24_share_if.sv
// Requester/result bus of mul24_share_ctrl; slave modport is the controller side.
interface mul24_share_if;
    import mul24_share_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic                res_valid;
    logic                res_ready;
    logic [IDW-1:0]      res_id;
    logic [PRODW-1:0]    res_prod;
    logic                busy;

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_prod, busy
    );

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_prod, busy
    );
endinterface

// File: rtl/mul_24x24.sv
// Unsigned 24x24 multiplier left in redundant carry/sum form; carry + sum = a * b (mod 2^48).
module mul_24x24
    import mul24_share_pkg::*;
(
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] carry,
    output logic [PRODW-1:0] sum
);
    logic [PRODW-1:0] pp;
    logic [PRODW-1:0] s_acc;
    logic [PRODW-1:0] c_acc;
    logic [PRODW-1:0] s_nxt;

    // Carry-save accumulation of one partial product per multiplier bit.
    always_comb begin
        pp    = '0;
        s_acc = '0;
        c_acc = '0;
        s_nxt = '0;
        for (int unsigned i = 0; i < OPW; i++) begin
            pp    = b[i] ? (PRODW'(a) << i) : '0;
            s_nxt = s_acc ^ c_acc ^ pp;
            c_acc = ((s_acc & c_acc) | (s_acc & pp) | (c_acc & pp)) << 1;
            s_acc = s_nxt;
        end
        carry = c_acc;
        sum   = s_acc;
    end
endmodule

// File: rtl/mul24_share_ctrl.sv
// Four requesters share one mul_24x24 through a 2-stage elastic pipeline.
// Define MUL24_SHARE_RR_EN for round-robin arbitration; default is fixed priority.
module mul24_share_ctrl
    import mul24_share_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mul24_share_if.slave bus
);
    logic             s1_valid, s2_valid;
    logic [OPW-1:0]   s1_a, s1_b;
    logic [IDW-1:0]   s1_id, s2_id;
    logic [PRODW-1:0] s2_carry, s2_sum;
    logic [PRODW-1:0] mul_carry, mul_sum;

    logic             s2_adv, s1_adv, s1_can_accept;
    logic             win_any, hs;
    logic [IDW-1:0]   win_id, idx;
    logic [NREQ-1:0]  ready_w;

    assign s2_adv        = !s2_valid || bus.res_ready;
    assign s1_adv        = s1_valid && s2_adv;
    assign s1_can_accept = !s1_valid || s1_adv;

`ifdef MUL24_SHARE_RR_EN
    logic [IDW-1:0] ptr;

    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + IDW'(k);
            if (!win_any && bus.req_valid[idx]) begin
                win_any = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (hs)
            ptr <= win_id + IDW'(1);
    end
`else
    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'(k);
            if (!win_any && bus.req_valid[idx]) begin
                win_any = 1'b1;
                win_id  = idx;
            end
        end
    end
`endif

    // Grant is gated by rst so req_ready is low throughout reset, not just after an edge.
    assign hs = win_any && s1_can_accept && !rst;

    always_comb begin
        ready_w = '0;
        if (hs)
            ready_w[win_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (s1_can_accept) begin
            s1_valid <= hs;
            if (hs) begin
                s1_a  <= bus.req_a[OPW*win_id +: OPW];
                s1_b  <= bus.req_b[OPW*win_id +: OPW];
                s1_id <= win_id;
            end
        end
    end

    mul_24x24 u_mul (
        .a     (s1_a),
        .b     (s1_b),
        .carry (mul_carry),
        .sum   (mul_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_carry <= '0;
            s2_sum   <= '0;
            s2_id    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_carry <= mul_carry;
                s2_sum   <= mul_sum;
                s2_id    <= s1_id;
            end
        end
    end

    assign bus.req_ready = ready_w;
    assign bus.res_valid = s2_valid;
    assign bus.res_id    = s2_id;
    assign bus.res_prod  = s2_carry + s2_sum;
    assign bus.busy      = s1_valid | s2_valid;
endmodule
